// File: rtl/shotclock_pkg.sv
// Shared types and helpers for the shot/game clock engine.
package shotclock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_EXPIRED
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_BLANK  = 4'hF;
  localparam int   MAX_DIGITS = 4;

  // Elaboration-time integer to packed BCD, least-significant digit in [3:0].
  function automatic logic [4*MAX_DIGITS-1:0] to_bcd(input int value);
    logic [4*MAX_DIGITS-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Saturating BCD down-counter: N_DIG digits with a ripple borrow chain.
module bcd_down_counter #(
  parameter int                 N_DIG     = 3,
  parameter logic [4*N_DIG-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [4*N_DIG-1:0] load_val,
  input  logic               dec,
  output logic [4*N_DIG-1:0] q,
  output logic               zero
);

  logic [4*N_DIG-1:0] q_dec;
  logic               borrow;

  assign zero = (q == '0);

  // Borrow ripples up from the lowest digit; a zero digit under borrow wraps to 9.
  always_comb begin
    // NOTE: every variable gets a value before any branch, so no latch can be inferred.
    q_dec  = q;
    borrow = 1'b1;
    for (int i = 0; i < N_DIG; i++) begin
      if (borrow) begin
        if (q[4*i +: 4] == 4'd0) begin
          q_dec[4*i +: 4] = 4'd9;
        end else begin
          q_dec[4*i +: 4] = q[4*i +: 4] - 4'd1;
          borrow          = 1'b0;
        end
      end
    end
  end

  // Count register: load beats decrement; decrement stops at zero.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (dec && !zero) begin
      q <= q_dec;
    end
  end

endmodule

// File: rtl/shot_clock_core.sv
// Shot/game clock: tenths BCD countdown, pause/resume, reloads, tenths display, buzzer.
module shot_clock_core
  import shotclock_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int N_DIGITS      = 2,
  parameter int FULL_LOAD     = 24,
  parameter int SHORT_LOAD    = 14,
  parameter int TENTHS_EN     = 1,
  parameter int TENTHS_THRESH = 5,
  parameter int BUZZ_CYCLES   = CLK_HZ / 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  load_full,
  input  logic                  load_short,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [N_DIGITS-1:0]   dp_mask,
  output logic                  running,
  output logic                  expired,
  output logic                  buzzer
);

  localparam int PRESC_N = CLK_HZ / 10;
  localparam int PRESC_W = (PRESC_N > 1) ? $clog2(PRESC_N) : 1;
  localparam int BUZZ_W  = (BUZZ_CYCLES > 0) ? $clog2(BUZZ_CYCLES + 1) : 1;
  localparam int CNT_W   = 4 * (N_DIGITS + 1);

  localparam logic [PRESC_W-1:0]      PRESC_TC  = PRESC_W'(PRESC_N - 1);
  localparam logic [4*MAX_DIGITS-1:0] FULL_BCD  = to_bcd(FULL_LOAD);
  localparam logic [4*MAX_DIGITS-1:0] SHORT_BCD = to_bcd(SHORT_LOAD);
  localparam logic [CNT_W-1:0]        FULL_VAL  = {FULL_BCD[4*N_DIGITS-1:0], 4'h0};
  localparam logic [CNT_W-1:0]        SHORT_VAL = {SHORT_BCD[4*N_DIGITS-1:0], 4'h0};
  localparam logic [CNT_W-1:0]        ONE_TENTH = CNT_W'(1);

  state_t              state, state_next;
  logic [PRESC_W-1:0]  presc;
  logic [BUZZ_W-1:0]   buzz_cnt;
  logic [CNT_W-1:0]    count;
  logic                count_zero;
  logic                any_load;
  logic                tick;
  logic                dec_en;
  logic                buzz_load;
  int                  sec_val;
  logic                tenths_mode;
  logic                leading;

  assign any_load = load_full | load_short;
  assign tick     = (state == ST_RUN) && (presc == PRESC_TC);
  assign dec_en   = tick && !any_load && !stop;
  assign buzzer   = (buzz_cnt != '0);

  bcd_down_counter #(
    .N_DIG     (N_DIGITS + 1),
    .RESET_VAL (FULL_VAL)
  ) u_count (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (any_load),
    .load_val (load_full ? FULL_VAL : SHORT_VAL),
    .dec      (dec_en),
    .q        (count),
    .zero     (count_zero)
  );

  // Next state: load > stop > start; the final tick in RUN expires the clock.
  always_comb begin
    state_next = state;
    buzz_load  = 1'b0;
    unique case (state)
      ST_IDLE, ST_PAUSE: begin
        if (!any_load && !stop && start) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (any_load) begin
          state_next = ST_RUN;
        end else if (stop) begin
          state_next = ST_PAUSE;
        end else if (tick && (count == ONE_TENTH || count_zero)) begin
          state_next = ST_EXPIRED;
          buzz_load  = 1'b1;
        end
      end
      ST_EXPIRED: begin
        if (any_load) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register with registered status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      running <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == ST_RUN);
      expired <= (state_next == ST_EXPIRED);
    end
  end

  // Prescaler: clears on load or a fresh start, advances only while staying in RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (any_load || (state == ST_IDLE && state_next == ST_RUN)) begin
      presc <= '0;
    end else if (state == ST_RUN && state_next == ST_RUN) begin
      presc <= (presc == PRESC_TC) ? '0 : presc + 1'b1;
    end
  end

  // Buzzer timer: armed on expiry, cleared by any load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buzz_cnt <= '0;
    end else if (any_load) begin
      buzz_cnt <= '0;
    end else if (buzz_load) begin
      buzz_cnt <= BUZZ_W'(BUZZ_CYCLES);
    end else if (buzz_cnt != '0) begin
      buzz_cnt <= buzz_cnt - 1'b1;
    end
  end

  // Display mapping: tenths mode below threshold, else right-aligned seconds with blanking.
  always_comb begin
    sec_val = 0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      sec_val = sec_val * 10 + int'(count[4*(i+1) +: 4]);
    end
    tenths_mode = (TENTHS_EN != 0) && (sec_val < TENTHS_THRESH);
    digits      = {N_DIGITS{BCD_BLANK}};
    dp_mask     = '0;
    leading     = 1'b1;
    if (tenths_mode) begin
      digits[3:0] = count[3:0];
      digits[7:4] = count[7:4];
      dp_mask[1]  = 1'b1;
    end else begin
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
        if (leading && i != 0 && count[4*(i+1) +: 4] == 4'd0) begin
          digits[4*i +: 4] = BCD_BLANK;
        end else begin
          digits[4*i +: 4] = count[4*(i+1) +: 4];
          leading          = 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_shot_clock_core.sv
// Scoreboard bench for shot_clock_core at 1 kHz, 2 digits, 50-cycle buzzer.
module tb_shot_clock_core;

  localparam int CLK_HZ    = 1000;
  localparam int N_DIGITS  = 2;
  localparam int BUZZ      = 50;
  localparam int FULL_S    = 24;
  localparam int SHORT_S   = 14;
  localparam int THRESH    = 5;
  localparam int PER_TICK  = CLK_HZ / 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, load_full = 1'b0, load_short = 1'b0;
  logic [7:0] digits;
  logic [1:0] dp_mask;
  logic       running, expired, buzzer;

  shot_clock_core #(
    .CLK_HZ        (CLK_HZ),
    .N_DIGITS      (N_DIGITS),
    .FULL_LOAD     (FULL_S),
    .SHORT_LOAD    (SHORT_S),
    .TENTHS_EN     (1),
    .TENTHS_THRESH (THRESH),
    .BUZZ_CYCLES   (BUZZ)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .load_full  (load_full),
    .load_short (load_short),
    .digits     (digits),
    .dp_mask    (dp_mask),
    .running    (running),
    .expired    (expired),
    .buzzer     (buzzer)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] digits;
    logic [1:0] dp;
    logic       running;
    logic       expired;
    logic       buzzer;
  } out_t;

  typedef struct packed {
    int   phase;
    out_t o;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  out_t act;
  int   checks = 0;
  int   errors = 0;
  int   phase  = 0;

  // Reference model: count kept as an integer number of tenths.
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_EXP} mode_t;
  mode_t m_st    = M_IDLE;
  int    m_tenth = FULL_S * 10;
  int    m_ph    = 0;
  int    m_bz    = 0;

  function automatic out_t model_out();
    out_t o;
    int sec;
    sec = m_tenth / 10;
    if (sec < THRESH) begin
      o.digits = {4'(sec % 10), 4'(m_tenth % 10)};
      o.dp     = 2'b10;
    end else begin
      o.digits = {(sec / 10 == 0) ? 4'hF : 4'(sec / 10), 4'(sec % 10)};
      o.dp     = 2'b00;
    end
    o.running = (m_st == M_RUN);
    o.expired = (m_st == M_EXP);
    o.buzzer  = (m_bz > 0);
    return o;
  endfunction

  task automatic model_step(input bit s, input bit p, input bit lf, input bit ls, input bit rn);
    if (!rn) begin
      m_st = M_IDLE; m_tenth = FULL_S * 10; m_ph = 0; m_bz = 0;
    end else begin
      if (m_bz > 0) m_bz--;
      if (lf || ls) begin
        m_tenth = (lf ? FULL_S : SHORT_S) * 10;
        m_ph    = 0;
        m_bz    = 0;
        if (m_st == M_EXP) m_st = M_IDLE;
      end else if (p) begin
        if (m_st == M_RUN) m_st = M_PAUSE;
      end else if (m_st == M_RUN) begin
        if (m_ph == PER_TICK - 1) begin
          m_ph = 0;
          if (m_tenth <= 1) begin
            m_tenth = 0; m_st = M_EXP; m_bz = BUZZ;
          end else begin
            m_tenth--;
          end
        end else begin
          m_ph++;
        end
      end else if (s && (m_st == M_IDLE || m_st == M_PAUSE)) begin
        if (m_st == M_IDLE) m_ph = 0;
        m_st = M_RUN;
      end
    end
  endtask

  // Drive one cycle of inputs and queue the response expected after the next edge.
  task automatic step(input bit s, input bit p, input bit lf, input bit ls, input bit rn);
    exp_t e;
    @(negedge clk);
    start = s; stop = p; load_full = lf; load_short = ls; rst_n = rn;
    model_step(s, p, lf, ls, rn);
    e.phase = phase;
    e.o     = model_out();
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
  endtask

  task automatic run_to_expiry(input int extra);
    int guard;
    guard = 0;
    while (m_st != M_EXP && guard < 20000) begin
      step(0, 0, 0, 0, 1);
      guard++;
    end
    if (m_st != M_EXP) begin
      errors++;
      $display("FAIL expiry_budget phase %0d: model never expired", phase);
    end
    idle(extra);
  endtask

  task automatic check(input string name, input out_t got, input exp_t want);
    checks++;
    if (got !== want.o) begin
      errors++;
      $display("FAIL %s phase %0d t=%0t: got digits=%h dp=%b run=%b exp=%b buzz=%b, want digits=%h dp=%b run=%b exp=%b buzz=%b",
               name, want.phase, $time, got.digits, got.dp, got.running, got.expired, got.buzzer,
               want.o.digits, want.o.dp, want.o.running, want.o.expired, want.o.buzzer);
    end
  endtask

  // Monitor: one registered output set per edge, compared against the queued expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      act = '{digits: digits, dp: dp_mask, running: running, expired: expired, buzzer: buzzer};
      check("outputs", act, cur);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then start and run past the first decrement.
    phase = 0; step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    phase = 1; step(1, 0, 0, 0, 1); idle(250);
    // Short reload while running, run through tenths mode to expiry and full buzzer.
    phase = 2; step(0, 0, 0, 1, 1); run_to_expiry(BUZZ + 20);
    // Start ignored in EXPIRED; start and stop together ignored.
    step(1, 1, 0, 0, 1); step(1, 0, 0, 0, 1);
    // Load plus start from EXPIRED lands in IDLE with full count.
    phase = 4; step(1, 0, 1, 0, 1); idle(10);
    // Start and stop together in IDLE stays IDLE.
    step(1, 1, 0, 0, 1); idle(3);
    // Short load coincident with the first tick.
    phase = 5; step(1, 0, 0, 0, 1); idle(PER_TICK - 1); step(0, 0, 0, 1, 1); idle(150);
    // Pause at prescaler 40 for 500 cycles, then resume; held start is idempotent.
    phase = 3; step(0, 0, 1, 0, 1); idle(40); step(0, 1, 0, 0, 1); idle(500);
    step(1, 0, 0, 0, 1); step(1, 0, 0, 0, 1); idle(120);
    // Expire again and reset in the middle of the buzzer.
    phase = 6; step(0, 0, 0, 1, 1); run_to_expiry(20); step(0, 0, 0, 0, 0); idle(5);
    // Randomised pulses against the model.
    phase = 7;
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(99) < 5, $urandom_range(99) < 2, $urandom_range(999) < 3,
           $urandom_range(999) < 3, $urandom_range(999) != 0);
    end
    @(negedge clk); @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shot_clock_core.md
# shot_clock_core

Parametrised shot/game-clock engine for the scoreboard display path. It replaces the fixed 2-digit, load-and-run seconds counter with:
- a tenths-resolution BCD countdown with configurable digit count;
- full and short reload values;
- pause/resume;
- a tenths display mode below a threshold;
- a timed buzzer.

It sits between the debounced button pulses and `sevenseg_mux`. Its digit outputs feed the mux `d*` inputs directly, using 4'hF as the blank code.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency; must be divisible by 10.
- `N_DIGITS`, 2, displayed digits (2..4).
- `FULL_LOAD`, 24, full reload value in whole seconds; must be < 10**N_DIGITS.
- `SHORT_LOAD`, 14, short reload value in whole seconds; must be ≤ FULL_LOAD.
- `TENTHS_EN`, 1, enables the tenths display mode.
- `TENTHS_THRESH`, 5, tenths mode is shown while whole seconds < this value.
- `BUZZ_CYCLES`, CLK_HZ/2, buzzer length in clock cycles.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous reset, active-low.
- `start`  in  1  one-cycle pulse: run or resume.
- `stop`  in  1  one-cycle pulse: pause.
- `load_full`  in  1  one-cycle pulse: load FULL_LOAD.0.
- `load_short`  in  1  one-cycle pulse: load SHORT_LOAD.0.
- `digits`  out  4*N_DIGITS  BCD digits; [3:0] is the rightmost digit; 4'hF means blank.
- `dp_mask`  out  N_DIGITS  decimal-point enable per digit.
- `running`  out  1  high in RUN.
- `expired`  out  1  high in EXPIRED.
- `buzzer`  out  1  high for BUZZ_CYCLES cycles after expiry.

## Operation
**Internal count**
- BCD seconds digits (N_DIGITS of them) plus one tenths digit.
- Decrement by 0.1 s with a borrow chain.

**Prescaler**
- Counts 0..CLK_HZ/10-1 in RUN only.
- Terminal count produces `tick`.
- Holds its value in PAUSE.
- Clears on load, on reset, and on entry to RUN from IDLE.

**FSM states:** IDLE, RUN, PAUSE, EXPIRED.
- IDLE: `start` → RUN.
- RUN: `stop` → PAUSE.
- RUN: a `tick` while the count is 0.1 → count becomes 0.0, state goes to EXPIRED, buzzer counter is loaded.
- PAUSE: `start` → RUN. Prescaler resumes from its held value.
- EXPIRED: `start` and `stop` are ignored; a load → IDLE.
- Load in RUN: count is reloaded and the state stays RUN, matching possession-reset behaviour.
- Load in IDLE or PAUSE: count is reloaded and the state is unchanged.

**Priority (same cycle):** `load_full` > `load_short` > `stop` > `start`. For example, `start` and `stop` together in IDLE leave the state in IDLE.

**Buzzer**
- Down-counter of width clog2(BUZZ_CYCLES+1).
- Any load or reset clears it immediately.

**Display mapping**
- Tenths mode: TENTHS_EN=1 and seconds < TENTHS_THRESH, in any state.
  - Rightmost digit = tenths.
  - Next digit = seconds ones, with its `dp_mask` bit set.
  - Remaining digits = 4'hF.
- Otherwise: whole seconds, right-aligned, `dp_mask` = 0.
  - Leading zeros are blanked to 4'hF.
  - The ones digit is never blanked, so 0 is shown as "0".

## Timing
**Reset values**
- count = FULL_LOAD.0
- state = IDLE
- `running` = 0, `expired` = 0, `buzzer` = 0
- prescaler = 0
- `digits` show FULL_LOAD; `dp_mask` = 0

**Latency**
- All outputs are registered.
- `start` at cycle n → `running` = 1 at n+1.
- First decrement lands CLK_HZ/10 cycles after entering RUN from IDLE.
- A load at cycle n updates `digits` at n+1.
- Final tick at cycle n → `expired` and `buzzer` both high at n+1.
- `buzzer` is high for exactly BUZZ_CYCLES cycles.

**Boundary conditions**
- A tick and a load in the same cycle: the load wins and no decrement occurs.
- Count never underflows below 0.0.
- `rst_n` low mid-RUN or mid-buzzer: all state returns to reset values on the next edge.
- A pulse held high for multiple cycles acts as repeated pulses. `start` held is idempotent.

## Structure
- Package `shotclock_pkg`:
  - state enum (IDLE/RUN/PAUSE/EXPIRED);
  - `BCD_BLANK` = 4'hF;
  - a `bcd_t` 4-bit typedef.
- Sub-module `bcd_down_counter`:
  - parametrised digit chain with load value, decrement enable and zero flag;
  - instantiated once for tenths+seconds.
- Prescaler, FSM, buzzer and display mapping live in the top of the block.

## Test plan
All scenarios use CLK_HZ=1000, N_DIGITS=2, BUZZ_CYCLES=50 (100 cycles per 0.1 s).
1. Reset, then `start` → `running` next cycle; after 100 cycles the count is 23.9. `digits` stay 8'h24 until count < 24.0, then show 8'h23.
2. Run to expiry from `load_short` → at 4.9 s `digits` = {4'h4, 4'h9} with `dp_mask` = 2'b10. At 0.0, `expired` = 1 and `buzzer` is high for exactly 50 cycles. `digits` = {4'hF, 4'h0} is not shown because tenths mode applies: `digits` = {4'h0, 4'h0}, `dp_mask` = 2'b10.
3. `stop` mid-decrement at prescaler = 40, wait 500 cycles, then `start` → next decrement lands 60 cycles after resume and the count is unchanged during the pause.
4. `load_full` and `start` in the same cycle from EXPIRED → state IDLE, count 24.0, `buzzer` cleared, `running` = 0.
5. `load_short` in RUN coincident with a tick → count 14.0, no decrement, still RUN.
6. `rst_n` low during the buzzer → next cycle `buzzer` = 0, `expired` = 0, `digits` = 8'h24.
